// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   PC_WIDTH_DEF   default program counter / word address width
//   RESET_PC_DEF   default first fetch address after reset
//   FIFO_DEPTH_DEF default instruction buffer depth
//   INSTR_WIDTH    instruction word width
//   fetch_state_e  request FSM states
//   fetch_entry_t  buffer entry {pc, instr} at the default PC width
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned INSTR_WIDTH    = 16;

  // IDLE: no request, REQ: request outstanding, FULL: buffer cannot take another word
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the address it came from. The top
  // packs the same {pc, instr} layout into a flat vector so non-default PC
  // widths keep working.
  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0] pc;
    logic [INSTR_WIDTH-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        drop the head entry
//   flush_i      empty the buffer; wins over push and pop in the same cycle
//   head_o       head entry, read straight from registered storage
//   full_o       DEPTH entries held
//   empty_o      no entries held
//   count_o      current occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned      DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  // Protect the storage against pushes into a full buffer and pops of an empty one.
  assign doPush = push_i && (!full_o || pop_i);
  assign doPop  = pop_i && !empty_o;

  // Storage is reset to RESET_VAL so the head reads a defined value while empty.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (doPop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (doPush && !doPop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (doPop && !doPush) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding memory request and a
// small instruction buffer in front of the decoder.
// Optional feature macro: FETCH_STAGE_PERF_EN adds the bubble_count output.
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset (0 = reset)
//   imem_req      memory read request, held until imem_ack
//   imem_addr     word address of the request
//   imem_ack      request complete, imem_rdata valid this cycle
//   imem_rdata    instruction word from memory
//   fetch_valid   buffer head is valid
//   fetch_instr   head instruction word
//   fetch_pc      head instruction address
//   decode_ready  decoder takes the head when fetch_valid is high
//   redirect      single-cycle redirect pulse
//   redirect_pc   redirect target
//   bubble_count  (FETCH_STAGE_PERF_EN only) saturating count of cycles with
//                 decode_ready high and fetch_valid low
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEF),
  parameter int unsigned         FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic [PC_WIDTH-1:0]    fetch_pc,
  input  logic                   decode_ready,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [15:0]            bubble_count
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = PC_WIDTH + INSTR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] stale_q, stale_d;
  logic                drop_q, drop_d;
  logic                req_q, req_d;

  logic                push, pop, flush;
  logic [DW-1:0]       pushData, headData;
  logic                fifoFull, fifoEmpty;
  logic [CW-1:0]       fifoCount, countAfter;

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .WIDTH     (DW),
    .RESET_VAL ({RESET_PC, {INSTR_WIDTH{1'b0}}})
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (pushData),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (headData),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .count_o     (fifoCount)
  );

  assign pushData    = {pc_q, imem_rdata};
  assign fetch_valid = !fifoEmpty;
  assign fetch_pc    = headData[DW-1:INSTR_WIDTH];
  assign fetch_instr = headData[INSTR_WIDTH-1:0];
  assign imem_req    = req_q;
  // While a dropped request is still in flight the bus keeps its old address;
  // pc_q already holds the redirect target for the request that follows.
  assign imem_addr   = drop_q ? stale_q : pc_q;

  // Next-state logic. A redirect overrides everything: the buffer is flushed,
  // the pc jumps, and a request at the target is scheduled. A request that is
  // still waiting for its ack cannot be withdrawn, so it is marked to be
  // dropped; repeated redirects keep the original stale address on the bus.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stale_d    = stale_q;
    drop_d     = drop_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = fetch_valid && decode_ready;
    countAfter = fifoCount + CW'(1) - CW'(pop);

    if (redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = S_REQ;
      drop_d  = 1'b0;
      if (state_q == S_REQ && !imem_ack) begin
        drop_d = 1'b1;
        if (!drop_q) begin
          stale_d = pc_q;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = fifoFull ? S_FULL : S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              push = 1'b1;
              pc_d = pc_q + PC_WIDTH'(1);
              if (countAfter == DEPTH_C) begin
                state_d = S_FULL;
              end
            end
          end
        end
        S_FULL: begin
          if (pop) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  // State registers; imem_req gets its own flop so the bus sees a clean
  // registered request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
    end
  end

`ifdef FETCH_STAGE_PERF_EN
  logic [15:0] bubble_q;

  // Counts cycles where the decoder was ready but had nothing to take.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bubble_q <= '0;
    end else if (decode_ready && !fetch_valid && bubble_q != 16'hFFFF) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (PC_WIDTH 16, RESET_PC 0,
// FIFO_DEPTH 2). Directed vector table, hand-written corner sequences, then
// random traffic compared with a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int unsigned DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clock;
  logic        reset;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic        fetchValid;
  logic [15:0] fetchInstr;
  logic [15:0] fetchPc;
  logic        decodeReady;
  logic        redirect;
  logic [15:0] redirectPc;
`ifdef FETCH_STAGE_PERF_EN
  logic [15:0] bubbleCount;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  fetch_stage #(
    .PC_WIDTH   (16),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imemReq),
    .imem_addr    (imemAddr),
    .imem_ack     (imemAck),
    .imem_rdata   (imemRdata),
    .fetch_valid  (fetchValid),
    .fetch_instr  (fetchInstr),
    .fetch_pc     (fetchPc),
    .decode_ready (decodeReady),
    .redirect     (redirect),
    .redirect_pc  (redirectPc)
`ifdef FETCH_STAGE_PERF_EN
    ,
    .bubble_count (bubbleCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the buffer is a queue of fetched words, and a request is
  // outstanding whenever one was pending and not yet answered, or the buffer
  // has room, or a redirect just happened.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  entry_t      mBuf[$];
  logic        mReq;
  logic        mDrop;
  logic [15:0] mPc;
  logic [15:0] mStale;
  logic [15:0] mBubble;

  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expPc;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd37) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] modelAddr();
    return mDrop ? mStale : mPc;
  endfunction

  task automatic modelReset();
    mReq    = 1'b0;
    mDrop   = 1'b0;
    mPc     = RST_PC;
    mStale  = RST_PC;
    mBubble = 16'h0000;
    mBuf.delete();
  endtask

  task automatic modelAdvance(input logic ack, input logic ready, input logic redir,
                              input logic [15:0] rpc, input logic [15:0] rdata);
    logic valid;
    logic pop;
    valid = (mBuf.size() != 0);
    pop   = valid && ready;
    if (ready && !valid && mBubble != 16'hFFFF) mBubble = mBubble + 16'd1;
    if (redir) begin
      if (mReq && !ack) begin
        if (!mDrop) mStale = mPc;
        mDrop = 1'b1;
      end else begin
        mDrop = 1'b0;
      end
      mBuf.delete();
      mPc  = rpc;
      mReq = 1'b1;
    end else begin
      if (pop) void'(mBuf.pop_front());
      if (mReq && ack) begin
        if (mDrop) begin
          mDrop = 1'b0;
        end else begin
          mBuf.push_back('{mPc, rdata});
          mPc = mPc + 16'd1;
        end
      end
      mReq = (mReq && !ack) || (mBuf.size() < DEPTH);
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    check({name, ".req"}, imemReq, mReq);
    if (mReq) check({name, ".addr"}, imemAddr, modelAddr());
    check({name, ".valid"}, fetchValid, mBuf.size() != 0);
    if (mBuf.size() != 0) begin
      check({name, ".pc"}, fetchPc, mBuf[0].pc);
      check({name, ".instr"}, fetchInstr, mBuf[0].instr);
    end
`ifdef FETCH_STAGE_PERF_EN
    check({name, ".bubble"}, bubbleCount, mBubble);
`endif
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, ".req"}, imemReq, 1'b0);
    check({name, ".addr"}, imemAddr, RST_PC);
    check({name, ".valid"}, fetchValid, 1'b0);
    check({name, ".instr"}, fetchInstr, 16'h0000);
    check({name, ".pc"}, fetchPc, RST_PC);
`ifdef FETCH_STAGE_PERF_EN
    check({name, ".bubble"}, bubbleCount, 16'h0000);
`endif
  endtask

  // Called just after a falling edge: drives one cycle of inputs, advances the
  // model across the coming rising edge, and waits for the next falling edge.
  task automatic applyStimulus(input logic ack, input logic ready, input logic redir,
                               input logic [15:0] rpc);
    logic [15:0] rdata;
    rdata       = ack ? memWord(modelAddr()) : 16'($urandom);
    imemAck     = ack;
    decodeReady = ready;
    redirect    = redir;
    redirectPc  = rpc;
    imemRdata   = rdata;
    modelAdvance(ack, ready, redir, rpc, rdata);
    @(negedge clock);
  endtask

  task automatic step(input string name, input logic ack, input logic ready,
                      input logic redir, input logic [15:0] rpc);
    checkOutput(name);
    applyStimulus(ack, ready, redir, rpc);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] drained[$];

    // Reset release, ack every cycle, decoder always ready.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b1, 16'h0001};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b1, 16'h0002};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0004, 1'b1, 16'h0003};

    reset       = 1'b0;
    imemAck     = 1'b0;
    imemRdata   = 16'h0000;
    decodeReady = 1'b0;
    redirect    = 1'b0;
    redirectPc  = 16'h0000;
    modelReset();
    repeat (3) @(negedge clock);
    checkResetOutputs("reset");
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      check($sformatf("vec%0d.req", i), imemReq, vecs[i].expReq);
      check($sformatf("vec%0d.addr", i), imemAddr, vecs[i].expAddr);
      check($sformatf("vec%0d.valid", i), fetchValid, vecs[i].expValid);
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d.pc", i), fetchPc, vecs[i].expPc);
        check($sformatf("vec%0d.instr", i), fetchInstr, memWord(vecs[i].expPc));
      end
      applyStimulus(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
    end

    // Decoder stalls for 10 cycles while memory keeps acking.
    for (int i = 0; i < 10; i++) step("stall", 1'b1, 1'b0, 1'b0, 16'h0);
    check("stall.reqLow", imemReq, 1'b0);
    check("stall.headPc", fetchPc, 16'h0004);

    // Drain without acks: exactly two buffered words, in order.
    for (int i = 0; i < 3; i++) begin
      if (fetchValid) drained.push_back(fetchPc);
      step("drain", 1'b0, 1'b1, 1'b0, 16'h0);
    end
    check("drain.count", drained.size(), 2);
    check("drain.first", (drained.size() > 0) ? drained[0] : 16'hDEAD, 16'h0004);
    check("drain.second", (drained.size() > 1) ? drained[1] : 16'hDEAD, 16'h0005);

    // Resume: the next word is the one after the drained pair.
    step("resume", 1'b1, 1'b0, 1'b0, 16'h0);
    check("resume.pc", fetchPc, 16'h0006);
    step("resume2", 1'b0, 1'b1, 1'b0, 16'h0);

    // Wait states with a redirect in the middle: stale word is dropped.
    step("ws1", 1'b0, 1'b1, 1'b0, 16'h0);
    step("ws2", 1'b0, 1'b1, 1'b1, 16'h0100);
    check("ws.addrHeld", imemAddr, 16'h0007);
    check("ws.flushed", fetchValid, 1'b0);
    step("ws3", 1'b0, 1'b1, 1'b0, 16'h0);
    step("ws4", 1'b1, 1'b1, 1'b0, 16'h0);
    check("ws.newAddr", imemAddr, 16'h0100);
    check("ws.dropped", fetchValid, 1'b0);
    step("ws5", 1'b1, 1'b0, 1'b0, 16'h0);
    check("ws.pc", fetchPc, 16'h0100);

    // Address wrap from 0xFFFF (redirect lands together with an ack).
    step("wrap1", 1'b1, 1'b1, 1'b1, 16'hFFFF);
    check("wrap.addrFFFF", imemAddr, 16'hFFFF);
    step("wrap2", 1'b1, 1'b0, 1'b0, 16'h0);
    check("wrap.addr0", imemAddr, 16'h0000);
    check("wrap.pc", fetchPc, 16'hFFFF);

    // Redirect coincident with ack and pop.
    step("coinc1", 1'b1, 1'b1, 1'b1, 16'h0200);
    check("coinc.validLow", fetchValid, 1'b0);
    step("coinc2", 1'b1, 1'b0, 1'b0, 16'h0);
    check("coinc.pc", fetchPc, 16'h0200);

    // Back-to-back redirects: the last target wins.
    step("b2b1", 1'b0, 1'b0, 1'b1, 16'h0300);
    step("b2b2", 1'b0, 1'b0, 1'b1, 16'h0310);
    check("b2b.addrHeld", imemAddr, 16'h0201);
    step("b2b3", 1'b1, 1'b0, 1'b0, 16'h0);
    step("b2b4", 1'b1, 1'b0, 1'b0, 16'h0);
    check("b2b.pc", fetchPc, 16'h0310);

    // Reset asserted while a request is outstanding.
    step("pre", 1'b0, 1'b0, 1'b0, 16'h0);
    #2 reset = 1'b0;
    modelReset();
    #1 checkResetOutputs("midReset");
    @(negedge clock);
    reset = 1'b1;
    step("post0", 1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step("post", 1'b0, 1'b1, 1'b0, 16'h0);
    check("post.noPush", fetchValid, 1'b0);
`ifdef FETCH_STAGE_PERF_EN
    check("perf.bubble5", bubbleCount, 16'd5);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0), rpc);
    end
    checkOutput("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of the word address and program counter.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, minimum 2).
REQ-004 clock  in  1  single clock for all state, rising edge.
REQ-005 reset  in  1  asynchronous assert, active-low (0 = reset); all state clears immediately on assertion.
REQ-006 imem_req  out  1  instruction-memory read request, held high until acknowledged.
REQ-007 imem_addr  out  PC_WIDTH  word address of the current request, stable while imem_req is high and imem_ack is low.
REQ-008 imem_ack  in  1  request complete; imem_rdata valid in the same cycle; meaningful only while imem_req is high.
REQ-009 imem_rdata  in  16  instruction word.
REQ-010 fetch_valid  out  1  fetch_instr/fetch_pc hold a valid entry for the decoder.
REQ-011 fetch_instr  out  16  instruction word to the decoder.
REQ-012 fetch_pc  out  PC_WIDTH  address of fetch_instr.
REQ-013 decode_ready  in  1  decoder accepts the entry; transfer when fetch_valid and decode_ready are both high.
REQ-014 redirect  in  1  branch/jump redirect from downstream, single-cycle pulse.
REQ-015 redirect_pc  in  PC_WIDTH  target address, sampled when redirect is high.

Function
REQ-016 FSM states: IDLE (no request), REQ (request outstanding), FULL (buffer cannot accept another word).
REQ-017 IDLE->REQ when occupancy < FIFO_DEPTH; REQ->REQ on ack with space remaining after the push; REQ->FULL on ack that fills the buffer; FULL->REQ on the cycle after a pop.
REQ-018 At most one memory request is outstanding; imem_req is registered.
REQ-019 On imem_req and imem_ack: push {pc, rdata}, pc <= pc + 1 (wraps modulo 2^PC_WIDTH, all-ones -> 0), and imem_req may stay high at the new address the next cycle (back-to-back).
REQ-020 The buffer is FIFO ordered; fetch_valid = not empty; head entry is presented combinationally from registered storage.
REQ-021 Push and pop in the same cycle are both honoured; occupancy stays unchanged.
REQ-022 Latency: ack at edge N -> fetch_valid high after edge N when the buffer was empty.
REQ-023 Redirect: on the next edge flush the buffer (fetch_valid low), set pc <= redirect_pc, and target the next request at redirect_pc.
REQ-024 Redirect while a request is outstanding: that request is completed and its data discarded (drop flag), and a new request to redirect_pc follows.
REQ-025 Redirect in the same cycle as ack: discard the acked data, and clear the drop flag.
REQ-026 Redirect in the same cycle as a pop: the flush wins, and the popped entry counts as consumed.
REQ-027 Back-to-back redirects: the last one wins.

Reset
REQ-028 During reset: imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=RESET_PC, state IDLE, buffer empty, drop flag clear.
REQ-029 imem_req rises on the first rising edge after reset deasserts.
REQ-030 Reset asserted mid-request abandons that request, with no push after release.

Configuration
REQ-031 Macro FETCH_STAGE_PERF_EN adds output bubble_count (16 bits, saturating), counting cycles where decode_ready=1 and fetch_valid=0, cleared by reset.
REQ-032 Without FETCH_STAGE_PERF_EN, the port and counter are absent, and all other behaviour is identical.

Structure
REQ-033 Shared package fetch_pkg holds the PC_WIDTH and RESET_PC defaults, the FSM state typedef, and the buffer entry typedef {pc, instr}.
REQ-034 Buffer is sub-module fetch_fifo (parameterised depth, push/pop/flush, full/empty/count); the FSM and PC stay in fetch_stage.

Verification
REQ-035 Reset release, memory acks every cycle, decode_ready=1 -> addresses 0,1,2,3 fetched in order, with fetch_pc tracking and no gaps.
REQ-036 decode_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req low after FULL, and no word lost on resume.
REQ-037 Memory with 3 wait states, redirect to 0x0100 during the wait -> the stale word is dropped, and the next fetch_pc is 0x0100.
REQ-038 pc=0xFFFF acked -> next imem_addr is 0x0000.
REQ-039 Redirect coincident with ack and pop -> fetch_valid low next cycle, and the next delivered fetch_pc equals redirect_pc.
REQ-040 With FETCH_STAGE_PERF_EN, 5 empty cycles with decode_ready=1 -> bubble_count=5; reset asserted mid-request -> all outputs match REQ-028.
